// File: rtl/pipeline_types.sv
// Shared pipeline types: the IF/ID register layout and the fetch FSM encoding.
package pipeline_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // FETCH: request outstanding; DROP: request outstanding whose response is
  // stale; HOLD: a fetched word is parked while the decode stage is stalled.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetchState_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory request at a time, fills the
// IF/ID register, and handles stalls, flushes and branch redirects.
// Optional feature: define IF_MISALIGN_CHK_EN to trap branch targets that are
// not word aligned (oMisalign pulse, fetching halts until the next branch).
module instr_fetch
  import pipeline_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic        iBrTrue,
  input  logic [31:0] iBrTarget,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemData,
  output logic        oStall_IF,
  output logic        oMisalign,
  output if_id_t      oIF_ID
);

  fetchState_t state, nextState;
  logic [31:0] pc, dropAddr, holdInstr, memAddr, brAddr, deliverInstr;
  logic        memReq, ackEff, killAck, trapped, brBad, deliver, capture;

`ifdef IF_MISALIGN_CHK_EN
  logic misalignQ;

  assign brAddr = iBrTarget;
  assign brBad  = iBrTrue & (iBrTarget[1:0] != 2'b00);

  // One-cycle pulse on a bad target; fetching stays parked until the next branch.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      misalignQ <= 1'b0;
      trapped   <= 1'b0;
    end else begin
      misalignQ <= brBad;
      if (iBrTrue) trapped <= brBad;
    end
  end

  assign oMisalign = misalignQ;
`else
  logic unusedTgtBits;

  assign brAddr        = {iBrTarget[31:2], 2'b00};
  assign brBad         = 1'b0;
  assign trapped       = 1'b0;
  assign oMisalign     = 1'b0;
  assign unusedTgtBits = ^iBrTarget[1:0];
`endif

  // A reset that cut a request short makes the next-cycle ack stale.
  assign ackEff    = iMemAck & ~killAck;
  assign oMemReq   = memReq;
  assign oMemAddr  = memAddr;
  assign oStall_IF = memReq & ~ackEff;

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) state <= FETCH;
    else      state <= nextState;
  end

  // Next state, memory request and IF/ID load decisions.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nextState    = state;
    memReq       = 1'b0;
    memAddr      = pc;
    deliver      = 1'b0;
    deliverInstr = iMemData;
    capture      = 1'b0;

    case (state)
      FETCH:   memReq = ~trapped;
      DROP: begin
        memReq  = 1'b1;
        memAddr = dropAddr;
      end
      default: memReq = 1'b0;
    endcase

    if (iBrTrue) begin
      // An unanswered request must still complete; its data is thrown away.
      nextState = (memReq && !ackEff) ? DROP : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (memReq && ackEff && !iFlush) begin
            if (iStall) begin
              capture   = 1'b1;
              nextState = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end
        DROP:    if (ackEff) nextState = FETCH;
        HOLD: begin
          if (!iFlush && !iStall) begin
            deliver      = 1'b1;
            deliverInstr = holdInstr;
            nextState    = FETCH;
          end
        end
        default: nextState = FETCH;
      endcase
    end
  end

  // PC and IF/ID register, priority reset > branch > flush > stall > normal.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
      pc      <= RESET_PC;
      oIF_ID  <= '0;
      killAck <= memReq & ~iMemAck;
    end else begin
      killAck <= 1'b0;
      if (iBrTrue) begin
        if (!brBad) pc <= brAddr;
        oIF_ID.valid <= 1'b0;
      end else if (iFlush) begin
        oIF_ID.valid <= 1'b0;
      end else if (deliver) begin
        oIF_ID.pc    <= pc;
        oIF_ID.pc4   <= pc + 32'd4;
        oIF_ID.instr <= deliverInstr;
        oIF_ID.valid <= 1'b1;
        pc           <= pc + 32'd4;
      end else if (!iStall) begin
        oIF_ID.valid <= 1'b0;
      end
    end
  end

  // Parked word and stale request address.
  always_ff @(posedge iClk) begin
    // NOTE: pure data registers carry no reset; the FSM state says when they are meaningful.
    if (capture)            holdInstr <= iMemData;
    if (nextState == DROP)  dropAddr  <= memAddr;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, hand-written corner
// sequences, then randomized traffic against a program-order reference model.
module tb_instr_fetch;
  import pipeline_types::*;

  logic        iClk = 1'b0;
  logic        iRst, iStall, iFlush, iBrTrue, iMemAck;
  logic [31:0] iBrTarget, iMemData;
  logic        oMemReq, oStall_IF, oMisalign;
  logic [31:0] oMemAddr;
  if_id_t      oIF_ID;

  int nTests = 0;
  int nFail  = 0;

  always #5 iClk = ~iClk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStall    (iStall),
    .iFlush    (iFlush),
    .iBrTrue   (iBrTrue),
    .iBrTarget (iBrTarget),
    .oMemReq   (oMemReq),
    .oMemAddr  (oMemAddr),
    .iMemAck   (iMemAck),
    .iMemData  (iMemData),
    .oStall_IF (oStall_IF),
    .oMisalign (oMisalign),
    .oIF_ID    (oIF_ID)
  );

  typedef struct {
    logic        stall, ack, br, flush;
    logic [31:0] tgt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expStallIF;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input logic s, a, b, f, input logic [31:0] t,
                              input logic er, input logic [31:0] ea,
                              input logic es, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.ack = a; v.br = b; v.flush = f; v.tgt = t;
    v.expReq = er; v.expAddr = ea; v.expStallIF = es; v.expValid = ev; v.expPc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, a, b, f, input logic [31:0] t);
    iStall = s; iMemAck = a; iBrTrue = b; iFlush = f; iBrTarget = t;
    iMemData = memWord(oMemAddr);
  endtask

  task automatic nextCycle;
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          busy, latLeft, delivered;
    logic [31:0] memAddrQ, expNext, t;
    logic        s, a, b, f;
    if_id_t      pIf;

    // Reset release with ack tied high, latency, branch-while-pending,
    // stall-into-hold, flush, branch coincident with ack.
    vecs[0]  = mk(0,1,0,0,0,         1,32'h000,0, 0,32'h000);
    vecs[1]  = mk(0,1,0,0,0,         1,32'h004,0, 1,32'h000);
    vecs[2]  = mk(0,1,0,0,0,         1,32'h008,0, 1,32'h004);
    vecs[3]  = mk(0,1,0,0,0,         1,32'h00C,0, 1,32'h008);
    vecs[4]  = mk(0,0,0,0,0,         1,32'h010,1, 1,32'h00C);
    vecs[5]  = mk(0,0,0,0,0,         1,32'h010,1, 0,32'h000);
    vecs[6]  = mk(0,0,0,0,0,         1,32'h010,1, 0,32'h000);
    vecs[7]  = mk(0,1,0,0,0,         1,32'h010,0, 0,32'h000);
    vecs[8]  = mk(0,0,1,0,32'h200,   1,32'h014,1, 1,32'h010);
    vecs[9]  = mk(0,0,0,0,0,         1,32'h014,1, 0,32'h000);
    vecs[10] = mk(0,1,0,0,0,         1,32'h014,0, 0,32'h000);
    vecs[11] = mk(0,0,0,0,0,         1,32'h200,1, 0,32'h000);
    vecs[12] = mk(1,1,0,0,0,         1,32'h200,0, 0,32'h000);
    vecs[13] = mk(1,0,0,0,0,         0,32'h000,0, 0,32'h000);
    vecs[14] = mk(1,0,0,0,0,         0,32'h000,0, 0,32'h000);
    vecs[15] = mk(1,0,0,0,0,         0,32'h000,0, 0,32'h000);
    vecs[16] = mk(0,0,0,0,0,         0,32'h000,0, 0,32'h000);
    vecs[17] = mk(0,1,0,0,0,         1,32'h204,0, 1,32'h200);
    vecs[18] = mk(0,1,0,1,0,         1,32'h208,0, 1,32'h204);
    vecs[19] = mk(0,1,0,0,0,         1,32'h208,0, 0,32'h000);
    vecs[20] = mk(0,1,1,0,32'h300,   1,32'h20C,0, 1,32'h208);
    vecs[21] = mk(0,0,0,0,0,         1,32'h300,1, 0,32'h000);
    vecs[22] = mk(0,1,0,0,0,         1,32'h300,0, 0,32'h000);
    vecs[23] = mk(0,0,0,0,0,         1,32'h304,1, 1,32'h300);

    iRst = 1'b1;
    drive(0, 1, 0, 0, 0);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_valid", 32'(oIF_ID.valid), 32'd0);
    check("rst_pc", oIF_ID.pc, 32'd0);
    check("rst_misalign", 32'(oMisalign), 32'd0);
    nextCycle();
    iRst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].ack, vecs[i].br, vecs[i].flush, vecs[i].tgt);
      @(negedge iClk);
      check($sformatf("v%0d_req", i), 32'(oMemReq), 32'(vecs[i].expReq));
      if (vecs[i].expReq) check($sformatf("v%0d_addr", i), oMemAddr, vecs[i].expAddr);
      check($sformatf("v%0d_stallIF", i), 32'(oStall_IF), 32'(vecs[i].expStallIF));
      check($sformatf("v%0d_valid", i), 32'(oIF_ID.valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        check($sformatf("v%0d_pc", i), oIF_ID.pc, vecs[i].expPc);
        check($sformatf("v%0d_pc4", i), oIF_ID.pc4, vecs[i].expPc + 32'd4);
        check($sformatf("v%0d_instr", i), oIF_ID.instr, memWord(vecs[i].expPc));
      end
      nextCycle();
    end

    // PC wrap: branch to the last word, fetch it, next address is zero.
    drive(0, 1, 1, 0, 32'hFFFF_FFFC);
    @(negedge iClk);
    check("wrap_pre_addr", oMemAddr, 32'h304);
    nextCycle();
    drive(0, 1, 0, 0, 0);
    @(negedge iClk);
    check("wrap_addr", oMemAddr, 32'hFFFF_FFFC);
    check("wrap_valid0", 32'(oIF_ID.valid), 32'd0);
    nextCycle();
    drive(0, 0, 0, 0, 0);
    @(negedge iClk);
    check("wrap_next_addr", oMemAddr, 32'h0);
    check("wrap_pc", oIF_ID.pc, 32'hFFFF_FFFC);
    check("wrap_pc4", oIF_ID.pc4, 32'h0);
    check("wrap_valid", 32'(oIF_ID.valid), 32'd1);
    nextCycle();

    // Reset while the request to 0 is pending; the late ack must be ignored.
    iRst = 1'b1;
    drive(0, 0, 0, 0, 0);
    nextCycle();
    iRst = 1'b0;
    check("rstmid_valid", 32'(oIF_ID.valid), 32'd0);
    drive(0, 1, 0, 0, 0);
    @(negedge iClk);
    check("rstmid_req", 32'(oMemReq), 32'd1);
    check("rstmid_addr", oMemAddr, 32'h0);
    check("rstmid_stallIF", 32'(oStall_IF), 32'd1);
    nextCycle();
    check("late_ack_ignored", 32'(oIF_ID.valid), 32'd0);
    drive(0, 1, 0, 0, 0);
    @(negedge iClk);
    check("rstmid_refetch_addr", oMemAddr, 32'h0);
    nextCycle();
    check("rstmid_deliver_valid", 32'(oIF_ID.valid), 32'd1);
    check("rstmid_deliver_pc", oIF_ID.pc, 32'h0);

    // Misaligned branch target.
    drive(0, 1, 1, 0, 32'h102);
    nextCycle();
`ifdef IF_MISALIGN_CHK_EN
    check("mis_pulse", 32'(oMisalign), 32'd1);
    check("mis_noreq", 32'(oMemReq), 32'd0);
    check("mis_valid", 32'(oIF_ID.valid), 32'd0);
    drive(0, 0, 0, 0, 0);
    nextCycle();
    check("mis_pulse_end", 32'(oMisalign), 32'd0);
    check("mis_still_noreq", 32'(oMemReq), 32'd0);
    drive(0, 0, 1, 0, 32'h400);
    nextCycle();
    check("mis_recover_req", 32'(oMemReq), 32'd1);
    check("mis_recover_addr", oMemAddr, 32'h400);
`else
    check("mis_tied0", 32'(oMisalign), 32'd0);
    check("mis_req", 32'(oMemReq), 32'd1);
    check("mis_masked_addr", oMemAddr, 32'h100);
`endif

    // Randomized traffic: memory with random latency, random stall/flush/branch.
    // Reference: delivered instructions follow program order from the last
    // branch target, carry the memory word of their PC, and hold under stall.
    busy = 0; latLeft = 0; delivered = 0; memAddrQ = '0; expNext = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = ($urandom_range(0, 3) == 0);
      b = (cyc == 0) || ($urandom_range(0, 15) == 0);
      f = ($urandom_range(0, 15) == 0);
      t = (cyc == 0) ? 32'h800 : ($urandom_range(0, 1023) << 2);
      a = 1'b0;
      if (oMemReq) begin
        if (busy != 0) check("mem_addr_stable", oMemAddr, memAddrQ);
        else begin
          busy     = 1;
          memAddrQ = oMemAddr;
          latLeft  = int'($urandom_range(0, 3));
        end
        if (latLeft == 0) begin
          a    = 1'b1;
          busy = 0;
        end else begin
          latLeft--;
        end
      end else begin
        busy = 0;
      end
      drive(s, a, b, f, t);
      pIf = oIF_ID;
      nextCycle();
      if (b) begin
        check("rnd_br_valid", 32'(oIF_ID.valid), 32'd0);
        expNext = t;
      end else if (f) begin
        check("rnd_flush_valid", 32'(oIF_ID.valid), 32'd0);
      end else if (s) begin
        check("rnd_stall_hold", 32'(oIF_ID == pIf), 32'd1);
      end else if (oIF_ID.valid) begin
        check("rnd_pc", oIF_ID.pc, expNext);
        check("rnd_pc4", oIF_ID.pc4, expNext + 32'd4);
        check("rnd_instr", oIF_ID.instr, memWord(expNext));
        expNext = expNext + 32'd4;
        delivered++;
      end
    end
    check("rnd_progress", 32'(delivered > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port iClk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst  in  1  the reset, synchronous and active-high.
REQ-004 SHALL have port iStall  in  1  the pipeline stall from the hazard unit (oStall_IF).
REQ-005 SHALL have port iFlush  in  1  the IF flush from the hazard unit (oFlush_IF).
REQ-006 SHALL have port iBrTrue  in  1  the branch/jump taken signal from EX.
REQ-007 SHALL have port iBrTarget  in  32  the redirect address, valid when iBrTrue=1.
REQ-008 SHALL have port oMemReq  out  1  the instruction memory request.
REQ-009 SHALL have port oMemAddr  out  32  the fetch address.
REQ-010 SHALL have port iMemAck  in  1  the memory response; iMemData is valid in the same cycle.
REQ-011 SHALL have port iMemData  in  32  the instruction word.
REQ-012 SHALL have port oStall_IF  out  1  memory busy, driven to the hazard unit iStall_IF.
REQ-013 SHALL have port oMisalign  out  1  the misaligned-target pulse (see REQ-030).
REQ-014 SHALL have port oIF_ID  out  if_id_t  the IF/ID pipeline register {pc, pc4, instr, valid}.

Function
REQ-015 SHALL implement FSM states FETCH (request outstanding), DROP (request outstanding, response to be discarded) and HOLD (instruction captured while downstream is stalled).
REQ-016 SHALL, in FETCH and DROP, hold oMemReq=1 and oMemAddr stable until the iMemAck cycle; request-to-ack latency is 0..N cycles.
REQ-017 SHALL drive oStall_IF = oMemReq & ~iMemAck, purely combinational from state and iMemAck, with no path from iStall.
REQ-018 SHALL, on ack in FETCH with iStall=0, load oIF_ID <= {PC, PC+4, iMemData, 1}, set PC <= PC+4 and issue the next request in the following cycle, giving 1 instr/cycle at zero-latency ack.
REQ-019 SHALL, on ack in FETCH with iStall=1, capture the word into a hold buffer, go to HOLD, and leave oIF_ID unchanged.
REQ-020 SHALL, in HOLD, deassert oMemReq, and on iStall=0 move the buffer to oIF_ID, advance PC and return to FETCH.
REQ-021 SHALL, whenever iStall=1 and no ack occurs, leave oIF_ID and PC unchanged.
REQ-022 SHALL, on iBrTrue=1, set PC <= iBrTarget, set oIF_ID.valid <= 0 and discard any held word; the branch takes effect even while iStall=1.
REQ-023 SHALL, on iBrTrue=1 with a request outstanding and no ack, go to DROP, keeping the old address stable until ack, discard that response, then issue iBrTarget.
REQ-024 SHALL, on iBrTrue=1 coincident with iMemAck, discard the data and issue iBrTarget in the next cycle.
REQ-025 SHALL, on iFlush=1 without iBrTrue, clear oIF_ID.valid only.
REQ-026 SHALL apply priority iRst > iBrTrue > iFlush > iStall > normal.
REQ-027 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

Reset
REQ-028 SHALL, on iRst=1, set PC=RESET_PC, state=FETCH, oIF_ID='0, hold buffer empty and oMisalign=0; the first request to RESET_PC is issued in the first cycle after reset deasserts.
REQ-029 SHALL, on iRst asserted mid-request, drop the outstanding transaction with no wait for ack; a late ack in the cycle after reset SHALL be ignored.

Configuration
REQ-030 SHALL, with IF_MISALIGN_CHK_EN defined, on iBrTrue with iBrTarget[1:0]!=0, pulse oMisalign for one cycle, not redirect, and keep PC and oIF_ID.valid=0 until the next iBrTrue; without the macro, oMisalign is tied 0 and iBrTarget[1:0] is forced to 0.

Structure
REQ-031 SHALL take if_id_t and the fetch-state enum from package pipeline_types, with RESET_PC default declared there as a constant.
REQ-032 SHALL be a single module; the hold buffer is inline, with no sub-module.

Verification
REQ-033 SHALL cover reset release with ack tied 1: addresses 0,4,8,C in consecutive cycles, and oIF_ID.valid=1 from the second cycle.
REQ-034 SHALL cover ack delayed by 3 cycles: oStall_IF=1 for 3 cycles, with oMemAddr stable at 0x10.
REQ-035 SHALL cover iBrTrue with target 0x200 while the request to 0x14 is pending: the 0x14 response is discarded and the next request is 0x200 with valid=0 in between.
REQ-036 SHALL cover iStall=1 for 4 cycles with ack in the first: HOLD is entered, oMemReq=0, and instr appears on oIF_ID the cycle after stall drops.
REQ-037 SHALL cover PC=0xFFFF_FFFC with ack: the next address is 0x0000_0000.
REQ-038 SHALL cover, with IF_MISALIGN_CHK_EN defined, iBrTarget=0x102: a 1-cycle oMisalign pulse with no request to 0x102.
